uart_cmd_ctrl: RTL and testbench

- Framed command controller on the RS422/UART receive byte stream. It sits downstream of the UART receiver, which supplies the valid/din byte strobe.
- Hunts for a 2-byte header, then parses cmd, length, payload and checksum, with inter-byte timeout recovery.
- Dispatches each good frame in one of three ways: a register write, a timed system-reset pulse, or a generic command strobe.
- Keeps saturating good-frame and error counters for telemetry.

---
 rtl/uart_cmd_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// Framed command controller on a received UART byte stream: header hunt, cmd/len/payload/checksum
// parsing with inter-byte timeout, dispatch to register write, timed system reset or generic strobe.
module uart_cmd_ctrl #(
  parameter logic [7:0]  HDR0        = 8'hEB,
  parameter logic [7:0]  HDR1        = 8'h90,
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned RST_PULSE   = 16,
  parameter logic [7:0]  CMD_WR      = 8'h01,
  parameter logic [7:0]  CMD_RST     = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [7:0]  din,
  output logic        reg_wr_en,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        sys_rst_n,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [31:0] cmd_arg,
  output logic        err_pulse,
  output logic [7:0]  ok_cnt,
  output logic [7:0]  err_cnt
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RST_W = $clog2(RST_PULSE + 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_PULSE - 1);

  typedef enum logic [2:0] {IDLE, HDR, CMD, LEN, DATA, CSUM, EXEC} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, len_q, idx_q, sum_q;
  logic [31:0]      arg_q;
  logic [TMO_W-1:0] tmo_q;
  logic [RST_W-1:0] rst_cnt_q;
  logic             tmo_expire;
  logic             err_d, wr_d, rst_d, gen_d, ok_d;

  assign tmo_expire = (state_q inside {HDR, CMD, LEN, DATA, CSUM}) && !valid && (tmo_q == TMO_LAST);
  assign ok_d       = wr_d | rst_d | gen_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, error detection and dispatch decode
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    wr_d    = 1'b0;
    rst_d   = 1'b0;
    gen_d   = 1'b0;
    case (state_q)
      IDLE: if (valid && din == HDR0) state_d = HDR;
      HDR: if (valid) begin
        if (din == HDR1)      state_d = CMD;
        else if (din == HDR0) state_d = HDR;
        else                  state_d = IDLE;
      end
      CMD: if (valid) state_d = LEN;
      LEN: if (valid) begin
        if (din > MAX_LEN_B) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (din == 8'd0) begin
          state_d = CSUM;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (valid && idx_q == len_q - 8'd1) state_d = CSUM;
      CSUM: if (valid) begin
        if (din == sum_q) begin
          state_d = EXEC;
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      EXEC: begin
        // A byte arriving during dispatch is treated as a fresh IDLE byte
        state_d = (valid && din == HDR0) ? HDR : IDLE;
        if (cmd_q == CMD_WR) begin
          if (len_q == 8'd3) wr_d  = 1'b1;
          else               err_d = 1'b1;
        end else if (cmd_q == CMD_RST) begin
          if (len_q == 8'd0) rst_d = 1'b1;
          else               err_d = 1'b1;
        end else begin
          gen_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tmo_expire) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  // Frame datapath: command, length, running checksum, argument bytes, idle timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
      arg_q <= '0;
      tmo_q <= '0;
    end else begin
      tmo_q <= (valid || state_q == IDLE) ? '0 : TMO_W'(tmo_q + 1'b1);
      if (valid) begin
        case (state_q)
          CMD: begin
            cmd_q <= din;
            sum_q <= din;
            arg_q <= '0;
          end
          LEN: begin
            len_q <= din;
            sum_q <= sum_q + din;
            idx_q <= '0;
          end
          DATA: begin
            sum_q <= sum_q + din;
            idx_q <= idx_q + 8'd1;
            case (idx_q)
              8'd0:    arg_q[31:24] <= din;
              8'd1:    arg_q[23:16] <= din;
              8'd2:    arg_q[15:8]  <= din;
              8'd3:    arg_q[7:0]   <= din;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // Registered dispatch outputs, reset pulse timer and telemetry counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr_en <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      sys_rst_n <= 1'b1;
      rst_cnt_q <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_arg   <= '0;
      err_pulse <= 1'b0;
      ok_cnt    <= '0;
      err_cnt   <= '0;
    end else begin
      reg_wr_en <= wr_d;
      cmd_valid <= gen_d;
      err_pulse <= err_d;
      if (wr_d) begin
        reg_addr  <= arg_q[31:24];
        reg_wdata <= arg_q[23:8];
      end
      if (ok_d)  cmd_code <= cmd_q;
      if (gen_d) cmd_arg  <= arg_q;
      if (ok_d && ok_cnt != 8'hFF)   ok_cnt  <= ok_cnt + 8'd1;
      if (err_d && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      // A new reset command restarts the pulse even while one is running
      if (rst_d) begin
        sys_rst_n <= 1'b0;
        rst_cnt_q <= RST_LAST;
      end else if (!sys_rst_n) begin
        if (rst_cnt_q == '0) sys_rst_n <= 1'b1;
        else                 rst_cnt_q <= rst_cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frame table, exact-cycle corner sequences and randomized
// frames checked against a frame-level model built from the framing rules.
module tb_uart_cmd_ctrl;
  localparam int unsigned TMO  = 100;
  localparam int unsigned RSTP = 16;
  localparam int unsigned MAXL = 8;
  localparam int K_NONE = 0;
  localparam int K_WR   = 1;
  localparam int K_RST  = 2;
  localparam int K_CMD  = 3;
  localparam int K_ERR  = 4;

  typedef struct {
    logic [127:0] bytes;   // right-aligned, first byte most significant
    int           n;
    int           kind;
    logic [7:0]   addr;
    logic [15:0]  wdata;
    logic [7:0]   code;
    logic [31:0]  arg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [7:0]  din;
  logic        reg_wr_en;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        sys_rst_n;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_arg;
  logic        err_pulse;
  logic [7:0]  ok_cnt;
  logic [7:0]  err_cnt;

  uart_cmd_ctrl #(
    .HDR0(8'hEB), .HDR1(8'h90), .MAX_LEN(MAXL), .TIMEOUT_CYC(TMO),
    .RST_PULSE(RSTP), .CMD_WR(8'h01), .CMD_RST(8'h5A)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .din(din),
    .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_arg(cmd_arg), .err_pulse(err_pulse), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Pulse monitor
  int n_wr = 0, n_cmd = 0, n_err = 0, n_rstp = 0, rst_run = 0, rst_width = 0;
  always @(negedge clk) begin
    if (reg_wr_en) n_wr++;
    if (cmd_valid) n_cmd++;
    if (err_pulse) n_err++;
    if (!sys_rst_n) rst_run++;
    else if (rst_run != 0) begin
      rst_width = rst_run;
      rst_run   = 0;
      n_rstp++;
    end
  end

  int s_wr, s_cmd, s_err, s_rstp;
  int m_ok, m_err;
  logic [7:0]  m_addr, m_code;
  logic [15:0] m_wdata;
  logic [31:0] m_arg;
  logic [7:0]  fq[$];
  vec_t        vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    valid = 1'b1;
    din   = b;
    @(posedge clk);
    #1;
    valid = 1'b0;
    din   = 8'h00;
  endtask

  task automatic send_q(input int gapmax);
    for (int i = 0; i < fq.size(); i++) begin
      send_byte(fq[i]);
      if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
    end
  endtask

  task automatic load_vec(input vec_t v);
    fq.delete();
    for (int i = 0; i < v.n; i++) fq.push_back(v.bytes[8*(v.n-1-i) +: 8]);
  endtask

  task automatic snap();
    s_wr = n_wr; s_cmd = n_cmd; s_err = n_err; s_rstp = n_rstp;
  endtask

  task automatic model_reset();
    m_ok = 0; m_err = 0; m_addr = '0; m_wdata = '0; m_code = '0; m_arg = '0;
  endtask

  task automatic expect_frame(input string tag, input int kind, input logic [7:0] addr,
                              input logic [15:0] wdata, input logic [7:0] code, input logic [31:0] arg);
    idle(RSTP + 6);
    case (kind)
      K_WR:  begin m_ok++; m_addr = addr; m_wdata = wdata; m_code = code; end
      K_RST: begin m_ok++; m_code = code; end
      K_CMD: begin m_ok++; m_code = code; m_arg = arg; end
      K_ERR: m_err++;
      default: ;
    endcase
    chk({tag, "_wr_pulses"},  32'(n_wr - s_wr),     32'(kind == K_WR));
    chk({tag, "_cmd_pulses"}, 32'(n_cmd - s_cmd),   32'(kind == K_CMD));
    chk({tag, "_err_pulses"}, 32'(n_err - s_err),   32'(kind == K_ERR));
    chk({tag, "_rst_pulses"}, 32'(n_rstp - s_rstp), 32'(kind == K_RST));
    if (kind == K_RST) chk({tag, "_rst_width"}, 32'(rst_width), 32'(RSTP));
    chk({tag, "_reg_addr"},  32'(reg_addr),  32'(m_addr));
    chk({tag, "_reg_wdata"}, 32'(reg_wdata), 32'(m_wdata));
    chk({tag, "_cmd_code"},  32'(cmd_code),  32'(m_code));
    chk({tag, "_cmd_arg"},   cmd_arg,        m_arg);
    chk({tag, "_ok_cnt"},    32'(ok_cnt),    32'(sat(m_ok)));
    chk({tag, "_err_cnt"},   32'(err_cnt),   32'(sat(m_err)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r, kind;
    logic [7:0]  c, l, s, p;
    logic [31:0] a;
    bit bad;

    vt[0]  = '{128'hEB90_0103_1012_345A,          8,  K_WR,   8'h10, 16'h1234, 8'h01, 32'h0};
    vt[1]  = '{128'hEB_9022_02AA_5523,            7,  K_CMD,  8'h00, 16'h0,    8'h22, 32'hAA550000};
    vt[2]  = '{128'hEB_9022_02AA_5524,            7,  K_ERR,  8'h00, 16'h0,    8'h00, 32'h0};
    vt[3]  = '{128'hEB90_2209,                    4,  K_ERR,  8'h00, 16'h0,    8'h00, 32'h0};
    vt[4]  = '{128'hEB_EB90_0103_1012_345A,       9,  K_WR,   8'h10, 16'h1234, 8'h01, 32'h0};
    vt[5]  = '{128'hEB_905A_005A,                 5,  K_RST,  8'h00, 16'h0,    8'h5A, 32'h0};
    vt[6]  = '{128'hEB_9001_0210_1225,            7,  K_ERR,  8'h00, 16'h0,    8'h00, 32'h0};
    vt[7]  = '{128'hEB90_5A01_0762,               6,  K_ERR,  8'h00, 16'h0,    8'h00, 32'h0};
    vt[8]  = '{128'hEB_9033_0033,                 5,  K_CMD,  8'h00, 16'h0,    8'h33, 32'h0};
    vt[9]  = '{128'hEB_9044_0601_0203_0405_065F,  11, K_CMD,  8'h00, 16'h0,    8'h44, 32'h01020304};
    vt[10] = '{128'hEB00,                         2,  K_NONE, 8'h00, 16'h0,    8'h00, 32'h0};
    vt[11] = '{128'hEB_9077_0801_0203_0405_0607_08A3, 13, K_CMD, 8'h00, 16'h0, 8'h77, 32'h01020304};
    vt[12] = '{128'hEB_9022_02EB_909F,            7,  K_CMD,  8'h00, 16'h0,    8'h22, 32'hEB900000};
    vt[13] = '{128'hEB90_6601_AB12,               6,  K_CMD,  8'h00, 16'h0,    8'h66, 32'hAB000000};

    rst_n = 1'b0;
    valid = 1'b0;
    din   = 8'h00;
    model_reset();
    idle(3);
    chk("reset_reg_wr_en", 32'(reg_wr_en), 32'h0);
    chk("reset_reg_addr",  32'(reg_addr),  32'h0);
    chk("reset_reg_wdata", 32'(reg_wdata), 32'h0);
    chk("reset_sys_rst_n", 32'(sys_rst_n), 32'h1);
    chk("reset_cmd_valid", 32'(cmd_valid), 32'h0);
    chk("reset_cmd_code",  32'(cmd_code),  32'h0);
    chk("reset_cmd_arg",   cmd_arg,        32'h0);
    chk("reset_err_pulse", 32'(err_pulse), 32'h0);
    chk("reset_ok_cnt",    32'(ok_cnt),    32'h0);
    chk("reset_err_cnt",   32'(err_cnt),   32'h0);
    rst_n = 1'b1;
    idle(2);

    // Register write appears exactly two clocks after the checksum byte's valid
    load_vec(vt[0]);
    send_q(0);
    chk("wr_lat_early", 32'(reg_wr_en), 32'h0);
    idle(1);
    chk("wr_lat_pulse", 32'(reg_wr_en), 32'h1);
    chk("wr_lat_addr",  32'(reg_addr),  32'h10);
    chk("wr_lat_wdata", 32'(reg_wdata), 32'h1234);
    idle(1);
    chk("wr_lat_single", 32'(reg_wr_en), 32'h0);
    chk("wr_lat_ok_cnt", 32'(ok_cnt),    32'h1);
    m_ok = 1; m_addr = 8'h10; m_wdata = 16'h1234; m_code = 8'h01;
    idle(4);

    // Directed frame table
    for (int i = 0; i < 14; i++) begin
      snap();
      load_vec(vt[i]);
      send_q(0);
      expect_frame($sformatf("vec%0d", i), vt[i].kind, vt[i].addr, vt[i].wdata, vt[i].code, vt[i].arg);
    end

    // Second reset command mid-pulse restarts the count: 5 extra clocks of low time
    snap();
    load_vec(vt[5]);
    send_q(0);
    send_q(0);
    idle(30);
    chk("rst_extend_pulses", 32'(n_rstp - s_rstp), 32'h1);
    chk("rst_extend_width",  32'(rst_width),       32'(RSTP + 5));
    chk("rst_extend_no_cmd", 32'(n_cmd - s_cmd + n_wr - s_wr), 32'h0);
    m_ok += 2; m_code = 8'h5A;

    // Timeout after TMO idle clocks mid-frame
    s_err = n_err;
    fq.delete(); fq.push_back(8'hEB); fq.push_back(8'h90); fq.push_back(8'h22);
    send_q(0);
    idle(int'(TMO) - 1);
    chk("tmo_not_yet", 32'(err_pulse), 32'h0);
    idle(1);
    chk("tmo_err_pulse", 32'(err_pulse), 32'h1);
    idle(2);
    chk("tmo_err_count", 32'(n_err - s_err), 32'h1);
    m_err++;
    snap();
    load_vec(vt[1]);
    send_q(0);
    expect_frame("after_tmo", K_CMD, 8'h00, 16'h0, 8'h22, 32'hAA550000);

    // Byte landing on the expiry cycle is accepted
    snap();
    fq.delete(); fq.push_back(8'hEB); fq.push_back(8'h90); fq.push_back(8'h22);
    send_q(0);
    idle(int'(TMO) - 1);
    fq.delete(); fq.push_back(8'h02); fq.push_back(8'hAA); fq.push_back(8'h55); fq.push_back(8'h23);
    send_q(0);
    expect_frame("tmo_edge", K_CMD, 8'h00, 16'h0, 8'h22, 32'hAA550000);

    // Randomized frames against the frame-level model
    for (int f = 0; f < 40; f++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)       c = 8'h01;
      else if (r == 3) c = 8'h5A;
      else begin
        c = 8'($urandom_range(2, 255));
        if (c == 8'h5A) c = 8'h5B;
      end
      if (c == 8'h01)      l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, MAXL)) : 8'd3;
      else if (c == 8'h5A) l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'd0;
      else                 l = 8'($urandom_range(0, MAXL + 1));
      fq.delete();
      fq.push_back(8'hEB); fq.push_back(8'h90); fq.push_back(c); fq.push_back(l);
      s = c + l;
      a = '0;
      if (l > 8'(MAXL)) kind = K_ERR;
      else begin
        for (int i = 0; i < int'(l); i++) begin
          p = 8'($urandom);
          fq.push_back(p);
          s = s + p;
          if (i < 4) a[8*(3-i) +: 8] = p;
        end
        bad = ($urandom_range(0, 3) == 0);
        fq.push_back(bad ? 8'(s + 8'($urandom_range(1, 255))) : s);
        if (bad)              kind = K_ERR;
        else if (c == 8'h01)  kind = (l == 8'd3) ? K_WR : K_ERR;
        else if (c == 8'h5A)  kind = (l == 8'd0) ? K_RST : K_ERR;
        else                  kind = K_CMD;
      end
      snap();
      send_q(3);
      expect_frame($sformatf("rand%0d", f), kind, a[31:24], a[23:8], c, a);
    end

    // Error counter saturation
    snap();
    load_vec(vt[2]);
    for (int k = 0; k < 300; k++) send_q(0);
    idle(5);
    m_err += 300;
    chk("sat_err_pulses", 32'(n_err - s_err), 32'd300);
    chk("sat_err_cnt",    32'(err_cnt),       32'hFF);
    chk("sat_ok_cnt",     32'(ok_cnt),        32'(sat(m_ok)));

    // Reset mid-frame
    fq.delete();
    fq.push_back(8'hEB); fq.push_back(8'h90); fq.push_back(8'h01); fq.push_back(8'h03); fq.push_back(8'h10);
    send_q(0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ok_cnt",   32'(ok_cnt),    32'h0);
    chk("midrst_err_cnt",  32'(err_cnt),   32'h0);
    chk("midrst_reg_addr", 32'(reg_addr),  32'h0);
    chk("midrst_cmd_code", 32'(cmd_code),  32'h0);
    chk("midrst_cmd_arg",  cmd_arg,        32'h0);
    chk("midrst_sys_rst",  32'(sys_rst_n), 32'h1);
    idle(2);
    rst_n = 1'b1;
    model_reset();
    idle(1);
    snap();
    load_vec(vt[0]);
    send_q(0);
    expect_frame("post_rst", K_WR, 8'h10, 16'h1234, 8'h01, 32'h0);

    // Reset mid-pulse forces sys_rst_n high at once
    load_vec(vt[5]);
    send_q(0);
    idle(5);
    chk("pulse_active", 32'(sys_rst_n), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("pulse_killed", 32'(sys_rst_n), 32'h1);
    idle(2);
    rst_n = 1'b1;
    model_reset();
    idle(1);
    snap();
    load_vec(vt[13]);
    send_q(0);
    expect_frame("post_pulse_rst", K_CMD, 8'h00, 16'h0, 8'h66, 32'hAB000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
